// File: rtl/dsp_pd_pkg.sv
// Shared types and defaults for the DSP MAC pattern detector.
// Imported by the compare unit and the top.
package dsp_pd_pkg;

  typedef enum logic {
    CFG_PATTERN = 1'b0,
    CFG_MASK    = 1'b1
  } cfg_sel_e;

  localparam int DSP_A_W = 27;
  localparam int DSP_B_W = 18;
  localparam int DSP_P_W = 48;

  localparam logic [47:0] DSP_PATTERN_RST =
    48'h0000_0072_6967;

endpackage

// File: rtl/dsp_pd_compare.sv
// Masked equality of a value against a pattern and its complement.
// Mask bit 1 removes that bit from both comparisons.
module dsp_pd_compare
  import dsp_pd_pkg::*;
#(
  parameter int P_W = DSP_P_W
) (
  input  logic [P_W-1:0] value_i,
  input  logic [P_W-1:0] pattern_i,
  input  logic [P_W-1:0] mask_i,
  output logic           pat_o,
  output logic           patb_o
);

  assign pat_o  = &(~(value_i ^ pattern_i) | mask_i);
  assign patb_o = &(~(value_i ^ ~pattern_i) | mask_i);

endmodule

// File: rtl/dsp_mac_pattern_detect.sv
// Signed MAC with MREG-deep multiplier pipeline, P register and a
// runtime-programmable masked pattern detector with match counter.
module dsp_mac_pattern_detect
  import dsp_pd_pkg::*;
#(
  parameter int A_W   = DSP_A_W,
  parameter int B_W   = DSP_B_W,
  parameter int P_W   = DSP_P_W,
  parameter int MREG  = 2,
  parameter int CNT_W = 16,
  parameter logic [P_W-1:0] PATTERN_RST =
    P_W'(DSP_PATTERN_RST),
  parameter logic [P_W-1:0] MASK_RST = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic signed [A_W-1:0] a_i,
  input  logic signed [B_W-1:0] b_i,
  input  logic                  acc_en_i,
  input  logic                  acc_clr_i,
  input  logic                  cfg_we_i,
  input  logic                  cfg_sel_i,
  input  logic [P_W-1:0]        cfg_data_i,
  input  logic                  cnt_clr_i,
  output logic signed [P_W-1:0] p_o,
  output logic                  valid_o,
  output logic                  pat_det_o,
  output logic                  patb_det_o,
  output logic                  pat_det_past_o,
  output logic [CNT_W-1:0]      match_cnt_o
);

  localparam int M_W = A_W + B_W;

  if (MREG < 1 || MREG > 4) begin : g_bad_mreg
    $error("MREG must be 1..4");
  end
  if (P_W < M_W) begin : g_bad_pw
    $error("P_W must be >= A_W+B_W");
  end

  typedef struct packed {
    logic           v;
    logic           acc;
    logic           clr;
    logic [P_W-1:0] p;
  } mstage_t;

  logic                  in_v;
  logic                  in_acc;
  logic                  in_clr;
  logic signed [A_W-1:0] a_q;
  logic signed [B_W-1:0] b_q;
  logic signed [M_W-1:0] prod;
  mstage_t               m_in;
  mstage_t               m_last;

  logic [P_W-1:0]   pattern_q;
  logic [P_W-1:0]   mask_q;
  logic [P_W-1:0]   p_next;
  logic             pat_nx;
  logic             patb_nx;
  logic [P_W-1:0]   p_q;
  logic             v_q;
  logic             pat_q;
  logic             patb_q;
  logic             past_q;
  logic [CNT_W-1:0] cnt_q;

  // Operand capture; data only moves with a valid strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) in_v <= 1'b0;
    else       in_v <= valid_i;
    if (valid_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      in_acc <= acc_en_i;
      in_clr <= acc_clr_i;
    end
  end

  assign prod = a_q * b_q;

  assign m_in = '{
    v:   in_v,
    acc: in_acc,
    clr: in_clr,
    p:   P_W'(prod)
  };

  for (genvar i = 0; i < MREG; i++) begin : g_m
    mstage_t d;
    mstage_t q;
    if (i == 0) begin : g_first
      assign d = m_in;
    end else begin : g_next
      assign d = g_m[i-1].q;
    end
    // Product stage; each stage loads only on its own valid.
    always_ff @(posedge clk_i) begin
      if (rst_i) q.v <= 1'b0;
      else       q.v <= d.v;
      if (d.v) begin
        q.acc <= d.acc;
        q.clr <= d.clr;
        q.p   <= d.p;
      end
    end
  end

  assign m_last = g_m[MREG-1].q;

  // Next P: clear wins over accumulate; add wraps.
  always_comb begin
    p_next = m_last.p;
    if (m_last.acc && !m_last.clr)
      p_next = p_q + m_last.p;
  end

  dsp_pd_compare #(
    .P_W (P_W)
  ) u_cmp (
    .value_i   (p_next),
    .pattern_i (pattern_q),
    .mask_i    (mask_q),
    .pat_o     (pat_nx),
    .patb_o    (patb_nx)
  );

  // Pattern/mask registers; new value applies from next edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pattern_q <= PATTERN_RST;
      mask_q    <= MASK_RST;
    end else if (cfg_we_i) begin
      unique case (cfg_sel_e'(cfg_sel_i))
        CFG_PATTERN: pattern_q <= cfg_data_i;
        CFG_MASK:    mask_q    <= cfg_data_i;
        default:     pattern_q <= pattern_q;
      endcase
    end
  end

  // P register with flags kept aligned to it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q    <= 1'b0;
      p_q    <= '0;
      pat_q  <= 1'b0;
      patb_q <= 1'b0;
      past_q <= 1'b0;
    end else begin
      v_q <= m_last.v;
      if (m_last.v) begin
        p_q    <= p_next;
        pat_q  <= pat_nx;
        patb_q <= patb_nx;
        past_q <= pat_q;
      end
    end
  end

  // Saturating match counter; clear beats increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i)
      cnt_q <= '0;
    else if (m_last.v && pat_nx && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end

  assign p_o            = p_q;
  assign valid_o        = v_q;
  assign pat_det_o      = pat_q;
  assign patb_det_o     = patb_q;
  assign pat_det_past_o = past_q;
  assign match_cnt_o    = cnt_q;

endmodule

// File: tb/tb_dsp_mac_pattern_detect.sv
// Directed bench for dsp_mac_pattern_detect (MREG=2, CNT_W=4).
// Expected values are hand-derived constants.
module tb_dsp_mac_pattern_detect;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               valid_i;
  logic signed [26:0] a_i;
  logic signed [17:0] b_i;
  logic               acc_en_i;
  logic               acc_clr_i;
  logic               cfg_we_i;
  logic               cfg_sel_i;
  logic [47:0]        cfg_data_i;
  logic               cnt_clr_i;
  logic [47:0]        p_o;
  logic               valid_o;
  logic               pat_det_o;
  logic               patb_det_o;
  logic               pat_det_past_o;
  logic [3:0]         match_cnt_o;

  int checks = 0;
  int failures = 0;

  logic   vin[9];
  logic   ev[9];
  longint ep[9];

  dsp_mac_pattern_detect #(
    .MREG  (2),
    .CNT_W (4)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .acc_en_i       (acc_en_i),
    .acc_clr_i      (acc_clr_i),
    .cfg_we_i       (cfg_we_i),
    .cfg_sel_i      (cfg_sel_i),
    .cfg_data_i     (cfg_data_i),
    .cnt_clr_i      (cnt_clr_i),
    .p_o            (p_o),
    .valid_o        (valid_o),
    .pat_det_o      (pat_det_o),
    .patb_det_o     (patb_det_o),
    .pat_det_past_o (pat_det_past_o),
    .match_cnt_o    (match_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic op(input logic [26:0] a,
                    input logic [17:0] b,
                    input logic acc,
                    input logic clr);
    valid_i   = 1'b1;
    a_i       = a;
    b_i       = b;
    acc_en_i  = acc;
    acc_clr_i = clr;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic cfg(input logic sel,
                     input logic [47:0] data);
    cfg_we_i   = 1'b1;
    cfg_sel_i  = sel;
    cfg_data_i = data;
    tick();
    cfg_we_i = 1'b0;
  endtask

  task automatic run_burst(input string tag, input int n);
    logic first;
    first = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (vin[k]) begin
        valid_i   = 1'b1;
        a_i       = 27'sd3;
        b_i       = 18'sd4;
        acc_clr_i = first;
        acc_en_i  = !first;
        first     = 1'b0;
      end else begin
        valid_i = 1'b0;
      end
      tick();
      chk($sformatf("%s_v[%0d]", tag, k),
          64'(valid_o), 64'(ev[k]));
      if (k >= 3)
        chk($sformatf("%s_p[%0d]", tag, k),
            64'(p_o), 64'(ep[k]));
    end
    valid_i = 1'b0;
  endtask

  task automatic scen1(input string tag);
    op(27'sd7498087, 18'sd1, 1'b0, 1'b0);
    tick();
    tick();
    chk({tag, "_early"}, 64'(valid_o), 64'd0);
    tick();
    chk({tag, "_v"}, 64'(valid_o), 64'd1);
    chk({tag, "_p"}, 64'(p_o), 64'h726967);
    chk({tag, "_pat"}, 64'(pat_det_o), 64'd1);
    chk({tag, "_patb"}, 64'(patb_det_o), 64'd0);
    chk({tag, "_cnt"}, 64'(match_cnt_o), 64'd1);
  endtask

  initial begin
    rst_i      = 1'b1;
    valid_i    = 1'b0;
    a_i        = '0;
    b_i        = '0;
    acc_en_i   = 1'b0;
    acc_clr_i  = 1'b0;
    cfg_we_i   = 1'b0;
    cfg_sel_i  = 1'b0;
    cfg_data_i = '0;
    cnt_clr_i  = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;

    chk("rst_v", 64'(valid_o), 64'd0);
    chk("rst_p", 64'(p_o), 64'd0);
    chk("rst_pat", 64'(pat_det_o), 64'd0);
    chk("rst_patb", 64'(patb_det_o), 64'd0);
    chk("rst_past", 64'(pat_det_past_o), 64'd0);
    chk("rst_cnt", 64'(match_cnt_o), 64'd0);

    scen1("s1");
    tick();
    chk("s1_hold_v", 64'(valid_o), 64'd0);
    chk("s1_hold_p", 64'(p_o), 64'h726967);

    cfg(1'b1, 48'hFF);
    op(27'h7269AB, 18'sd1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("s2m_pat", 64'(pat_det_o), 64'd1);
    chk("s2m_cnt", 64'(match_cnt_o), 64'd2);

    cfg(1'b0, 48'h0);
    cfg(1'b1, 48'h0);
    op(27'h7FF_FFFF, 18'sd1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("s2c_p", 64'(p_o), 64'hFFFF_FFFF_FFFF);
    chk("s2c_patb", 64'(patb_det_o), 64'd1);
    chk("s2c_pat", 64'(pat_det_o), 64'd0);
    chk("s2c_past", 64'(pat_det_past_o), 64'd1);

    vin = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
            1'b0, 1'b0, 1'b0, 1'b0};
    ev  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
            1'b1, 1'b1, 1'b0, 1'b0};
    ep  = '{0, 0, 0, 12, 24, 36, 48, 48, 48};
    run_burst("s3a", 8);

    vin = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
            1'b0, 1'b0, 1'b0, 1'b0};
    ev  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
            1'b0, 1'b1, 1'b1, 1'b0};
    ep  = '{0, 0, 0, 12, 24, 24, 36, 48, 48};
    run_burst("s3g", 9);

    cfg(1'b0, 48'h7FFF_FFFF_FFFF);
    for (int i = 0; i < 15; i++)
      op(27'h400_0000, 18'h2_0000, i != 0, i == 0);
    op(27'h400_0000, 18'h2_0001, 1'b1, 1'b0);
    op(27'h3FF_FFFF, 18'sd1, 1'b1, 1'b0);
    op(27'sd1, 18'sd1, 1'b1, 1'b0);
    tick();
    tick();
    chk("s4_max_p", 64'(p_o), 64'h7FFF_FFFF_FFFF);
    chk("s4_max_pat", 64'(pat_det_o), 64'd1);
    tick();
    chk("s4_wrap_p", 64'(p_o), 64'h8000_0000_0000);
    chk("s4_wrap_pat", 64'(pat_det_o), 64'd0);
    chk("s4_wrap_patb", 64'(patb_det_o), 64'd1);
    chk("s4_wrap_past", 64'(pat_det_past_o), 64'd1);
    chk("s4_cnt", 64'(match_cnt_o), 64'd3);

    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    chk("s5_clr", 64'(match_cnt_o), 64'd0);
    cfg(1'b1, 48'hFFFF_FFFF_FFFF);
    for (int i = 0; i < 20; i++)
      op(27'sd1, 18'sd1, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    chk("s5_sat", 64'(match_cnt_o), 64'd15);
    op(27'sd2, 18'sd1, 1'b0, 1'b1);
    tick();
    tick();
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    chk("s5_cm_v", 64'(valid_o), 64'd1);
    chk("s5_cm_pat", 64'(pat_det_o), 64'd1);
    chk("s5_cm_cnt", 64'(match_cnt_o), 64'd0);
    op(27'sd3, 18'sd1, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    chk("s5_inc", 64'(match_cnt_o), 64'd1);

    op(27'sd5, 18'sd1, 1'b0, 1'b1);
    op(27'sd6, 18'sd1, 1'b0, 1'b1);
    op(27'sd7, 18'sd1, 1'b0, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("s6_flush_v[%0d]", k),
          64'(valid_o), 64'd0);
      tick();
    end
    chk("s6_p", 64'(p_o), 64'd0);
    chk("s6_cnt", 64'(match_cnt_o), 64'd0);
    scen1("s6r");
    op(27'sd7498088, 18'sd1, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    chk("s6_mask_rst", 64'(pat_det_o), 64'd0);
    chk("s6_cnt_hold", 64'(match_cnt_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
